fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/pc_reg.sv | 38 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath width, base opcodes, fetch FSM encoding and default reset PC.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_ADD    = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE  = 2'd0;
    localparam fetch_state_t FETCH_WAIT  = 2'd1;
    localparam fetch_state_t FETCH_VALID = 2'd2;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC select; a misaligned branch target leaves the PC untouched.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            update,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_q, pc_d;

    assign pc_plus4   = pc_q + 32'd4;
    assign misaligned = update && pc_src && (branch_target[1:0] != 2'b00);
    assign pc         = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (update && !misaligned) begin
            pc_d = pc_src ? branch_target : pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> WAIT -> VALID handshake with instruction memory.
// Optional WAIT timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_start,
    input  logic            pc_update,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    output logic            i_mem_req,
    output logic [XLEN-1:0] i_mem_addr,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic [XLEN-1:0] ir,
    output logic [6:0]      opcode,
    output logic            ir_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_err
);

    fetch_state_t    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic            err_q, err_d;
    logic            pc_upd;
    logic            misaligned;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] tmo_q, tmo_d;
`endif

    // pc_update is honoured only outside an outstanding memory request
    assign pc_upd = pc_update && (state_q != FETCH_WAIT);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .update        (pc_upd),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        err_d      = err_q | misaligned;
`ifdef FETCH_TIMEOUT_EN
        tmo_d      = 4'd0;
`endif
        case (state_q)
            FETCH_IDLE: begin
                // A fault raised by a same-cycle pc_update also blocks the fetch
                if (fetch_start && !err_d) begin
                    state_d = FETCH_WAIT;
                    req_d   = 1'b1;
                end
            end
            FETCH_WAIT: begin
                if (i_mem_ack) begin
                    ir_d       = i_mem_rdata;
                    ir_valid_d = 1'b1;
                    req_d      = 1'b0;
                    state_d    = FETCH_VALID;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_q == 4'hF) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = FETCH_IDLE;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
`endif
            end
            FETCH_VALID: begin
                if (pc_update) begin
                    ir_valid_d = 1'b0;
                    state_d    = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            req_q      <= 1'b0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 4'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign i_mem_req  = req_q;
    assign i_mem_addr = pc;
    assign ir         = ir_q;
    assign opcode     = ir_q[6:0];
    assign ir_valid   = ir_valid_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; honours FETCH_TIMEOUT_EN like the RTL.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_start;
    logic        pc_update;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        i_mem_req;
    logic [31:0] i_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic        ir_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_start   (fetch_start),
        .pc_update     (pc_update),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .i_mem_req     (i_mem_req),
        .i_mem_addr    (i_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .ir            (ir),
        .opcode        (opcode),
        .ir_valid      (ir_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_err     (fetch_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_start = 1'b0; pc_update = 1'b0; pc_src = 1'b0; branch_target = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        tick();
        tick();
        total++;
        if (pc !== 32'h0 || ir !== 32'h0 || ir_valid !== 1'b0 || i_mem_req !== 1'b0
            || fetch_err !== 1'b0) begin
            $display("FAIL reset_state: pc=%h ir=%h ir_valid=%b req=%b err=%b, want 0",
                     pc, ir, ir_valid, i_mem_req, fetch_err);
            bad++;
        end
        total++;
        if (pc_plus4 !== 32'h4) begin
            $display("FAIL reset_pc_plus4: got %h want 00000004", pc_plus4);
            bad++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_fetch();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        total++;
        if (i_mem_req !== 1'b1 || i_mem_addr !== 32'h0) begin
            $display("FAIL fetch_req: req=%b addr=%h want 1/00000000", i_mem_req, i_mem_addr);
            bad++;
        end
        tick();
        tick();
        total++;
        if (i_mem_req !== 1'b1 || ir_valid !== 1'b0 || i_mem_addr !== 32'h0) begin
            $display("FAIL wait_hold: req=%b ir_valid=%b addr=%h want 1/0/0",
                     i_mem_req, ir_valid, i_mem_addr);
            bad++;
        end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0020_8033;
        tick();
        i_mem_ack = 1'b0;
        total++;
        if (ir !== 32'h0020_8033 || opcode !== 7'b0110011 || ir_valid !== 1'b1
            || i_mem_req !== 1'b0) begin
            $display("FAIL ack_capture: ir=%h op=%b ir_valid=%b req=%b want 00208033/0110011/1/0",
                     ir, opcode, ir_valid, i_mem_req);
            bad++;
        end
        // stray ack and fetch_start in VALID must be ignored
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678; fetch_start = 1'b1;
        tick();
        i_mem_ack = 1'b0; fetch_start = 1'b0;
        total++;
        if (ir !== 32'h0020_8033 || ir_valid !== 1'b1 || i_mem_req !== 1'b0) begin
            $display("FAIL valid_ignore: ir=%h ir_valid=%b req=%b want 00208033/1/0",
                     ir, ir_valid, i_mem_req);
            bad++;
        end
        pc_update = 1'b1; pc_src = 1'b0;
        tick();
        pc_update = 1'b0;
        total++;
        if (pc !== 32'h4 || ir_valid !== 1'b0) begin
            $display("FAIL retire_seq: pc=%h ir_valid=%b want 00000004/0", pc, ir_valid);
            bad++;
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            pc_update = 1'b1; pc_src = 1'b0;
            tick();
        end
        pc_update = 1'b0;
        total++;
        if (pc !== 32'h10 || pc_plus4 !== 32'h14 || i_mem_req !== 1'b0) begin
            $display("FAIL idle_update: pc=%h pc4=%h req=%b want 00000010/00000014/0",
                     pc, pc_plus4, i_mem_req);
            bad++;
        end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        pc_update = 1'b1; pc_src = 1'b1; branch_target = 32'h80;
        tick();
        pc_update = 1'b0;
        total++;
        if (pc !== 32'h10 || i_mem_req !== 1'b1 || i_mem_addr !== 32'h10) begin
            $display("FAIL wait_update_ignored: pc=%h req=%b addr=%h want 00000010/1/00000010",
                     pc, i_mem_req, i_mem_addr);
            bad++;
        end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0013;
        tick();
        i_mem_ack = 1'b0;
        pc_update = 1'b1; pc_src = 1'b1; branch_target = 32'h40;
        tick();
        pc_update = 1'b0;
        total++;
        if (pc !== 32'h40 || ir_valid !== 1'b0) begin
            $display("FAIL branch_taken: pc=%h ir_valid=%b want 00000040/0", pc, ir_valid);
            bad++;
        end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        total++;
        if (i_mem_req !== 1'b1 || i_mem_addr !== 32'h40) begin
            $display("FAIL branch_refetch: req=%b addr=%h want 1/00000040", i_mem_req, i_mem_addr);
            bad++;
        end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0063;
        tick();
        i_mem_ack = 1'b0;
    endtask

    task automatic test_both_in_idle();
        pc_update = 1'b1; pc_src = 1'b0;
        tick();
        fetch_start = 1'b1;
        tick();
        pc_update = 1'b0; fetch_start = 1'b0;
        total++;
        if (pc !== 32'h48 || i_mem_req !== 1'b1 || i_mem_addr !== 32'h48) begin
            $display("FAIL start_and_update: pc=%h req=%b addr=%h want 00000048/1/00000048",
                     pc, i_mem_req, i_mem_addr);
            bad++;
        end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_006F;
        tick();
        i_mem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        pc_update = 1'b1; pc_src = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        pc_update = 1'b0;
        total++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            $display("FAIL top_of_space: pc=%h pc4=%h want fffffffc/00000000", pc, pc_plus4);
            bad++;
        end
        pc_update = 1'b1; pc_src = 1'b0;
        tick();
        pc_update = 1'b0;
        total++;
        if (pc !== 32'h0) begin
            $display("FAIL pc_wrap: got %h want 00000000", pc);
            bad++;
        end
    endtask

    task automatic test_reset_in_wait();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (i_mem_req !== 1'b0 || ir !== 32'h0 || ir_valid !== 1'b0) begin
            $display("FAIL async_reset_wait: req=%b ir=%h ir_valid=%b want 0/0/0",
                     i_mem_req, ir, ir_valid);
            bad++;
        end
        tick();
        rst_n = 1'b1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        tick();
        i_mem_ack = 1'b0;
        tick();
        total++;
        if (i_mem_req !== 1'b0 || ir !== 32'h0 || ir_valid !== 1'b0 || pc !== 32'h0) begin
            $display("FAIL late_ack: req=%b ir=%h ir_valid=%b pc=%h want 0/0/0/0",
                     i_mem_req, ir, ir_valid, pc);
            bad++;
        end
    endtask

    task automatic test_misaligned();
        pc_update = 1'b1; pc_src = 1'b1; branch_target = 32'h42;
        tick();
        pc_update = 1'b0;
        total++;
        if (fetch_err !== 1'b1 || pc !== 32'h0) begin
            $display("FAIL misaligned_target: err=%b pc=%h want 1/00000000", fetch_err, pc);
            bad++;
        end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        total++;
        if (i_mem_req !== 1'b0 || fetch_err !== 1'b1) begin
            $display("FAIL err_blocks_fetch: req=%b err=%b want 0/1", i_mem_req, fetch_err);
            bad++;
        end
    endtask

    task automatic test_timeout();
        bit held = 1'b1;
        apply_reset();
        total++;
        if (fetch_err !== 1'b0) begin
            $display("FAIL err_cleared_by_reset: got %b want 0", fetch_err);
            bad++;
        end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            if (i_mem_req !== 1'b1) held = 1'b0;
            tick();
        end
        total++;
        if (!held || i_mem_req !== 1'b1 || fetch_err !== 1'b0) begin
            $display("FAIL timeout_early: held=%b req=%b err=%b want 1/1/0",
                     held, i_mem_req, fetch_err);
            bad++;
        end
        tick();
        total++;
        if (i_mem_req !== 1'b0 || fetch_err !== 1'b1) begin
            $display("FAIL timeout_fire: req=%b err=%b want 0/1", i_mem_req, fetch_err);
            bad++;
        end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        total++;
        if (i_mem_req !== 1'b0) begin
            $display("FAIL timeout_idle: req=%b want 0", i_mem_req);
            bad++;
        end
`else
        for (int i = 0; i < 100; i++) begin
            if (i_mem_req !== 1'b1 || fetch_err !== 1'b0) held = 1'b0;
            tick();
        end
        total++;
        if (!held || i_mem_req !== 1'b1) begin
            $display("FAIL no_timeout: held=%b req=%b want 1/1", held, i_mem_req);
            bad++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_branch();
        test_both_in_idle();
        test_wrap();
        test_reset_in_wait();
        test_misaligned();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
